// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: pixel source that sits right after the VGA timing generator.
// Derives active-area x/y from pixel_enable_in / vs_in, renders one of four
// test patterns (solid, colour bars, checkerboard, bouncing box) and delays the
// sync/enable strobes so everything leaves aligned with a fixed 2-cycle latency.
// Optional build macro: VGA_PATTERN_BORDER_EN forces a one-pixel white frame
// around the active area in every mode.
module vga_pattern_gen #(
    parameter int HD         = 1280,
    parameter int VD         = 1024,
    parameter int X_BITS     = 11,
    parameter int Y_BITS     = 11,
    parameter int BOX_SIZE   = 64,
    parameter int CHECK_LOG2 = 5
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic        pixel_enable_in,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic [1:0]  mode,
    input  logic [11:0] color_in,
    output logic [11:0] rgb_out,
    output logic        de_out,
    output logic        hs_out,
    output logic        vs_out
);

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BOX   = 2'd3
    } mode_e;

    localparam logic [X_BITS-1:0] X_ONE      = X_BITS'(1);
    localparam logic [Y_BITS-1:0] Y_ONE      = Y_BITS'(1);
    localparam logic [X_BITS-1:0] BAR_LAST   = X_BITS'(HD / 8 - 1);
    localparam logic [X_BITS-1:0] BOX_X_MAX  = X_BITS'(HD - BOX_SIZE);
    localparam logic [Y_BITS-1:0] BOX_Y_MAX  = Y_BITS'(VD - BOX_SIZE);
    localparam logic [X_BITS:0]   BOX_SPAN_X = (X_BITS + 1)'(BOX_SIZE);
    localparam logic [Y_BITS:0]   BOX_SPAN_Y = (Y_BITS + 1)'(BOX_SIZE);

    // Coordinate tracking
    logic [X_BITS-1:0] x_cnt;
    logic [Y_BITS-1:0] y_cnt;
    logic              pe_d;
    logic              vs_d;
    logic              frame_tick;

    // Bar index tracked incrementally so no divider is needed
    logic [2:0]        bar_idx;
    logic [X_BITS-1:0] bar_pix;

    // Per-frame state
    mode_e             mode_q;
    logic [X_BITS-1:0] box_x;
    logic [Y_BITS-1:0] box_y;
    logic              dx_pos;
    logic              dy_pos;

    // Stage-0 combinational features of the current pixel
    logic [X_BITS:0]   box_x_end;
    logic [Y_BITS:0]   box_y_end;
    logic              in_box;
    logic              check_bit;

    // Stage 1
    logic              s1_de;
    logic              s1_hs;
    logic              s1_vs;
    mode_e             s1_mode;
    logic [11:0]       s1_color;
    logic [2:0]        s1_bar;
    logic              s1_check;
    logic              s1_in_box;

    // Stage 2 colour selection
    logic [11:0]       bar_color;
    logic [11:0]       pix_color;

`ifdef VGA_PATTERN_BORDER_EN
    logic              on_border;
    logic              s1_border;

    assign on_border = (x_cnt == '0) || (x_cnt == X_BITS'(HD - 1)) ||
                       (y_cnt == '0) || (y_cnt == Y_BITS'(VD - 1));
`endif

    assign frame_tick = vs_in & ~vs_d;

    // x counts enabled pixels in the line; y counts lines since the last vs rise.
    // NOTE: every sequential block uses non-blocking assignments so all
    // registers update from the same pre-edge values, matching the hardware.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            x_cnt <= '0;
            y_cnt <= '0;
            pe_d  <= 1'b0;
            vs_d  <= 1'b0;
        end else begin
            pe_d <= pixel_enable_in;
            vs_d <= vs_in;
            if (pixel_enable_in) begin
                x_cnt <= x_cnt + X_ONE;
            end else begin
                x_cnt <= '0;
            end
            if (frame_tick) begin
                y_cnt <= '0;
            end else if (pe_d && !pixel_enable_in) begin
                y_cnt <= y_cnt + Y_ONE;
            end
        end
    end

    // Bar index follows x_cnt, stepping every HD/8 pixels and saturating at 7.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            bar_idx <= '0;
            bar_pix <= '0;
        end else if (!pixel_enable_in) begin
            bar_idx <= '0;
            bar_pix <= '0;
        end else if (bar_pix == BAR_LAST) begin
            bar_pix <= '0;
            if (bar_idx != 3'd7) begin
                bar_idx <= bar_idx + 3'd1;
            end
        end else begin
            bar_pix <= bar_pix + X_ONE;
        end
    end

    // Mode latch and box motion, both only on the frame tick.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            mode_q <= MODE_SOLID;
            box_x  <= '0;
            box_y  <= '0;
            dx_pos <= 1'b1;
            dy_pos <= 1'b1;
        end else if (frame_tick) begin
            mode_q <= mode_e'(mode);

            if (dx_pos && box_x == BOX_X_MAX) begin
                dx_pos <= 1'b0;
                box_x  <= box_x - X_ONE;
            end else if (!dx_pos && box_x == '0) begin
                dx_pos <= 1'b1;
                box_x  <= X_ONE;
            end else begin
                box_x  <= dx_pos ? box_x + X_ONE : box_x - X_ONE;
            end

            if (dy_pos && box_y == BOX_Y_MAX) begin
                dy_pos <= 1'b0;
                box_y  <= box_y - Y_ONE;
            end else if (!dy_pos && box_y == '0) begin
                dy_pos <= 1'b1;
                box_y  <= Y_ONE;
            end else begin
                box_y  <= dy_pos ? box_y + Y_ONE : box_y - Y_ONE;
            end
        end
    end

    // Stage-0 features; the end bounds carry one extra bit so they cannot wrap.
    assign box_x_end = {1'b0, box_x} + BOX_SPAN_X;
    assign box_y_end = {1'b0, box_y} + BOX_SPAN_Y;
    assign in_box    = (x_cnt >= box_x) && ({1'b0, x_cnt} < box_x_end) &&
                       (y_cnt >= box_y) && ({1'b0, y_cnt} < box_y_end);
    assign check_bit = x_cnt[CHECK_LOG2] ^ y_cnt[CHECK_LOG2];

    // Stage 1: register pixel features and the delayed strobes.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            s1_de     <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_mode   <= MODE_SOLID;
            s1_color  <= '0;
            s1_bar    <= '0;
            s1_check  <= 1'b0;
            s1_in_box <= 1'b0;
`ifdef VGA_PATTERN_BORDER_EN
            s1_border <= 1'b0;
`endif
        end else begin
            s1_de     <= pixel_enable_in;
            s1_hs     <= hs_in;
            s1_vs     <= vs_in;
            s1_mode   <= mode_q;
            s1_color  <= color_in;
            s1_bar    <= bar_idx;
            s1_check  <= check_bit;
            s1_in_box <= in_box;
`ifdef VGA_PATTERN_BORDER_EN
            s1_border <= on_border;
`endif
        end
    end

    // Fixed colour-bar palette.
    // NOTE: each always_comb assigns its outputs a default first so no path
    // can leave them unassigned and infer a latch.
    always_comb begin
        bar_color = 12'h000;
        case (s1_bar)
            3'd0:    bar_color = 12'hFFF;
            3'd1:    bar_color = 12'hFF0;
            3'd2:    bar_color = 12'h0FF;
            3'd3:    bar_color = 12'h0F0;
            3'd4:    bar_color = 12'hF0F;
            3'd5:    bar_color = 12'hF00;
            3'd6:    bar_color = 12'h00F;
            default: bar_color = 12'h000;
        endcase
    end

    // Pattern mux for the pixel held in stage 1.
    always_comb begin
        pix_color = s1_color;
        case (s1_mode)
            MODE_SOLID: pix_color = s1_color;
            MODE_BARS:  pix_color = bar_color;
            MODE_CHECK: pix_color = s1_check ? ~s1_color : s1_color;
            MODE_BOX:   pix_color = s1_in_box ? s1_color : 12'h000;
            default:    pix_color = s1_color;
        endcase
`ifdef VGA_PATTERN_BORDER_EN
        if (s1_border) begin
            pix_color = 12'hFFF;
        end
`endif
    end

    // Stage 2: output registers; colour is forced black during blanking.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rgb_out <= '0;
            de_out  <= 1'b0;
            hs_out  <= 1'b0;
            vs_out  <= 1'b0;
        end else begin
            rgb_out <= s1_de ? pix_color : 12'h000;
            de_out  <= s1_de;
            hs_out  <= s1_hs;
            vs_out  <= s1_vs;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Testbench for vga_pattern_gen with a small 64x48 raster. A behavioural model
// derives each pixel's expected colour from its position in the line, the line
// count since vsync, the frame count and the pattern rules; outputs are compared
// two cycles later against a queue of expectations.
module tb_vga_pattern_gen;

    localparam int HD  = 64;
    localparam int VD  = 48;
    localparam int BOX = 8;
    localparam int CL2 = 2;

    logic        clk = 1'b0;
    logic        arstn;
    logic        pe;
    logic        hs;
    logic        vs;
    logic [1:0]  mode;
    logic [11:0] color_in;
    logic [11:0] rgb_out;
    logic        de_out;
    logic        hs_out;
    logic        vs_out;

    vga_pattern_gen #(
        .HD         (HD),
        .VD         (VD),
        .X_BITS     (11),
        .Y_BITS     (11),
        .BOX_SIZE   (BOX),
        .CHECK_LOG2 (CL2)
    ) dut (
        .clk             (clk),
        .arstn           (arstn),
        .pixel_enable_in (pe),
        .hs_in           (hs),
        .vs_in           (vs),
        .mode            (mode),
        .color_in        (color_in),
        .rgb_out         (rgb_out),
        .de_out          (de_out),
        .hs_out          (hs_out),
        .vs_out          (vs_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
    } out_t;

    int   checks = 0;
    int   errors = 0;
    out_t exp_q[$];

    // Model state: pixels seen so far in this line, lines since vsync,
    // frame ticks since reset, and the pattern chosen for this frame.
    int   mx;
    int   my;
    int   n_ticks;
    int   frame_mode;
    bit   pe_prev;
    bit   vs_prev;

    // Box position after n ticks: a triangle wave bouncing between 0 and range.
    function automatic int tri_pos(input int n, input int range);
        int m;
        m = n % (2 * range);
        return (m <= range) ? m : 2 * range - m;
    endfunction

    function automatic logic [11:0] bar_colour(input int bar);
        case (bar)
            0:       return 12'hFFF;
            1:       return 12'hFF0;
            2:       return 12'h0FF;
            3:       return 12'h0F0;
            4:       return 12'hF0F;
            5:       return 12'hF00;
            6:       return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [11:0] model_pixel(input int x, input int y, input int fmode,
                                                input logic [11:0] c);
        logic [11:0] p;
        int bar;
        int bx;
        int by;
        p = c;
        case (fmode)
            1: begin
                bar = x / (HD / 8);
                if (bar > 7) bar = 7;
                p = bar_colour(bar);
            end
            2: p = ((((x >> CL2) ^ (y >> CL2)) & 1) != 0) ? (c ^ 12'hFFF) : c;
            3: begin
                bx = tri_pos(n_ticks, HD - BOX);
                by = tri_pos(n_ticks, VD - BOX);
                p = (x >= bx && x < bx + BOX && y >= by && y < by + BOX) ? c : 12'h000;
            end
            default: p = c;
        endcase
`ifdef VGA_PATTERN_BORDER_EN
        if (x == 0 || x == HD - 1 || y == 0 || y == VD - 1) p = 12'hFFF;
`endif
        return p;
    endfunction

    task automatic model_reset();
        out_t z;
        z = '0;
        mx = 0;
        my = 0;
        n_ticks = 0;
        frame_mode = 0;
        pe_prev = 1'b0;
        vs_prev = 1'b0;
        exp_q.delete();
        exp_q.push_back(z);
        exp_q.push_back(z);
    endtask

    // One pixel clock: check the output due now, drive new inputs, queue their expectation.
    task automatic step(input logic p, input logic h, input logic v,
                        input logic [1:0] m, input logic [11:0] c);
        out_t got;
        out_t e;
        @(negedge clk);
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            got = {rgb_out, de_out, hs_out, vs_out};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL pixel t=%0t rgb/de/hs/vs got %h/%b/%b/%b expected %h/%b/%b/%b",
                         $time, got.rgb, got.de, got.hs, got.vs, e.rgb, e.de, e.hs, e.vs);
            end
        end
        pe = p;
        hs = h;
        vs = v;
        mode = m;
        color_in = c;
        e.rgb = p ? model_pixel(mx % 2048, my, frame_mode, c) : 12'h000;
        e.de  = p;
        e.hs  = h;
        e.vs  = v;
        exp_q.push_back(e);
        if (v && !vs_prev) begin
            my = 0;
            n_ticks++;
            frame_mode = int'(m);
        end else if (pe_prev && !p) begin
            my++;
        end
        mx = p ? mx + 1 : 0;
        pe_prev = p;
        vs_prev = v;
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic do_reset();
        #3;
        arstn = 1'b0;
        pe = 1'b0;
        hs = 1'b0;
        vs = 1'b0;
        #1;
        checks++;
        if ({rgb_out, de_out, hs_out, vs_out} !== 15'd0) begin
            errors++;
            $display("FAIL reset_async rgb/de/hs/vs got %h/%b/%b/%b expected 000/0/0/0",
                     rgb_out, de_out, hs_out, vs_out);
        end
        @(negedge clk);
        @(negedge clk);
        #2;
        arstn = 1'b1;
        model_reset();
    endtask

    function automatic logic [11:0] pick(input bit rnd, input logic [11:0] c);
        return rnd ? 12'($urandom) : c;
    endfunction

    task automatic run_line(input int act, input logic v, input logic [1:0] m,
                            input bit rnd, input logic [11:0] c);
        repeat (2) step(1'b0, 1'b0, v, m, pick(rnd, c));
        repeat (3) step(1'b0, 1'b1, v, m, pick(rnd, c));
        repeat (2) step(1'b0, 1'b0, v, m, pick(rnd, c));
        for (int i = 0; i < act; i++) step(1'b1, 1'b0, v, m, pick(rnd, c));
    endtask

    // Two vsync lines, one back-porch line, then VD active lines. The mode
    // input switches to m2 from line change_at onward (if change_at >= 0).
    task automatic run_frame(input logic [1:0] m, input bit rnd, input logic [11:0] c,
                             input int change_at, input logic [1:0] m2);
        run_line(0, 1'b1, m, rnd, c);
        run_line(0, 1'b1, m, rnd, c);
        run_line(0, 1'b0, m, rnd, c);
        for (int l = 0; l < VD; l++)
            run_line(HD, 1'b0, (change_at >= 0 && l >= change_at) ? m2 : m, rnd, c);
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        pe = 1'b0;
        hs = 1'b0;
        vs = 1'b0;
        mode = 2'd0;
        color_in = 12'h000;
        #1;
        checks++;
        if ({rgb_out, de_out, hs_out, vs_out} !== 15'd0) begin
            errors++;
            $display("FAIL reset_init rgb/de/hs/vs got %h/%b/%b/%b expected 000/0/0/0",
                     rgb_out, de_out, hs_out, vs_out);
        end
        @(negedge clk);
        #2;
        arstn = 1'b1;
        model_reset();
        // Part of a line with a lit pixel stream, then reset mid-line.
        run_line(20, 1'b0, 2'd0, 1'b0, 12'hABC);
        do_reset();
        run_line(30, 1'b0, 2'd0, 1'b1, 12'h000);
        run_line(HD, 1'b0, 2'd2, 1'b1, 12'h000);
    endtask

    task automatic test_solid();
        run_frame(2'd0, 1'b1, 12'h000, -1, 2'd0);
        run_frame(2'd0, 1'b0, 12'h123, -1, 2'd0);
    endtask

    task automatic test_bars();
        run_frame(2'd1, 1'b1, 12'h000, -1, 2'd1);
        // Enable held past HD: the bar index must stay at 7.
        run_line(HD + 6, 1'b0, 2'd1, 1'b1, 12'h000);
    endtask

    task automatic test_checker();
        run_frame(2'd2, 1'b0, 12'h0A5, -1, 2'd2);
        run_frame(2'd2, 1'b1, 12'h000, -1, 2'd2);
    endtask

    task automatic test_mode_change();
        logic [1:0] m1;
        logic [1:0] m2;
        m1 = 2'($urandom_range(0, 3));
        m2 = m1 + 2'($urandom_range(1, 3));
        run_frame(m1, 1'b1, 12'h000, 20, m2);
        run_frame(m2, 1'b1, 12'h000, -1, m2);
    endtask

    task automatic test_box();
        do_reset();
        // Frames with no active lines just advance the box.
        for (int k = 0; k < 55; k++) begin
            repeat (2) step(1'b0, 1'b0, 1'b1, 2'd3, 12'h000);
            repeat (2) step(1'b0, 1'b0, 1'b0, 2'd3, 12'h000);
        end
        run_frame(2'd3, 1'b0, 12'hE71, -1, 2'd3);
        run_frame(2'd3, 1'b1, 12'h000, -1, 2'd3);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++)
            run_frame(2'($urandom_range(0, 3)), 1'b1, 12'h000, -1, 2'd0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 2'd0, 12'h000);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_solid();
        test_bars();
        test_checker();
        test_mode_change();
        test_box();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
